// File: rtl/l1_l2_request_arbiter_pkg.sv
// Shared L2 command encodings, default widths and FIFO entry layout for the
// L1-to-L2 request path.
package l2_if_pkg;

  localparam int L2_ADDR_W_DEF = 26;
  localparam int L2_CMD_W_DEF  = 2;
  localparam int L2_NUM_CH_DEF = 2;

  typedef enum logic [L2_CMD_W_DEF-1:0] {
    L2_READ      = 2'd0,
    L2_WRITE     = 2'd1,
    L2_RFO       = 2'd2,
    L2_WRITEBACK = 2'd3
  } l2_cmd_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int L2_SRC_W_DEF = src_width(L2_NUM_CH_DEF);

  typedef struct packed {
    logic [L2_CMD_W_DEF-1:0]  cmd;
    logic [L2_ADDR_W_DEF-1:0] addr;
    logic [L2_SRC_W_DEF-1:0]  src;
  } l2_entry_t;

endpackage

// File: rtl/l1_l2_request_arbiter_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after i_ptr (mod NUM_CH)
// when enabled, returning both a one-hot grant and its encoded index.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic              i_en,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_CH-1:0] o_grant,
  output logic [IDX_W-1:0]  o_idx
);

  int               w_sum;
  logic [IDX_W-1:0] w_ch;
  logic             w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = 0;
    w_ch    = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_sum = (int'(i_ptr) + k) % NUM_CH;
      w_ch  = IDX_W'(w_sum);
      if (i_en && !w_found && i_req[w_ch]) begin
        o_grant[w_ch] = 1'b1;
        o_idx         = w_ch;
        w_found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_l2_request_arbiter.sv
// N-channel L1 request arbiter feeding a DEPTH-entry FIFO that drains to the
// single L2 command port; also counts requests forwarded to L2.
module l1_l2_request_arbiter
  import l2_if_pkg::*;
#(
  parameter int NUM_CH = L2_NUM_CH_DEF,
  parameter int ADDR_W = L2_ADDR_W_DEF,
  parameter int CMD_W  = L2_CMD_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic                          Clock,
  input  logic                          clear,
  input  logic [NUM_CH-1:0]             req_valid,
  input  logic [NUM_CH*CMD_W-1:0]       req_cmd,
  input  logic [NUM_CH*ADDR_W-1:0]      req_addr,
  output logic [NUM_CH-1:0]             req_ready,
  output logic                          l2_valid,
  input  logic                          l2_ready,
  output logic [CMD_W-1:0]              command_to_L2,
  output logic [ADDR_W-1:0]             addr_to_L2,
  output logic [src_width(NUM_CH)-1:0]  l2_src,
  output logic [31:0]                   fwd_count,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int SRC_W = src_width(NUM_CH);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [SRC_W-1:0]  src;
  } entry_t;

  logic [CMD_W-1:0]  w_cmd  [NUM_CH];
  logic [ADDR_W-1:0] w_addr [NUM_CH];

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign w_cmd[gi]  = req_cmd[gi*CMD_W +: CMD_W];
      assign w_addr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  entry_t            r_mem [DEPTH];
  entry_t            r_head_entry;
  logic [PTR_W-1:0]  r_head_ptr;
  logic [PTR_W-1:0]  r_tail_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [SRC_W-1:0]  r_rr_ptr;
  logic [31:0]       r_fwd_count;

  logic              w_pop;
  logic              w_accept;
  logic              w_push;
  logic [NUM_CH-1:0] w_grant;
  logic [SRC_W-1:0]  w_idx;
  entry_t            w_new;
  logic [PTR_W-1:0]  w_head_nxt_ptr;

  assign w_pop    = (r_count != '0) && l2_ready;
  // A full FIFO still accepts when its head leaves in the same cycle.
  assign w_accept = !clear && ((r_count < CNT_W'(DEPTH)) || w_pop);

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (SRC_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_en    (w_accept),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_push         = |w_grant;
  assign w_new          = '{cmd: w_cmd[w_idx], addr: w_addr[w_idx], src: w_idx};
  assign w_head_nxt_ptr = r_head_ptr + PTR_W'(1);

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_tail_ptr] <= w_new;
    end
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      r_head_ptr   <= '0;
      r_tail_ptr   <= '0;
      r_count      <= '0;
      r_rr_ptr     <= '0;
      r_fwd_count  <= '0;
      r_head_entry <= '0;
    end else begin
      if (w_push) begin
        r_tail_ptr <= r_tail_ptr + PTR_W'(1);
        r_rr_ptr   <= (w_idx == SRC_W'(NUM_CH - 1)) ? '0 : w_idx + SRC_W'(1);
      end
      if (w_pop) begin
        r_head_ptr  <= w_head_nxt_ptr;
        r_fwd_count <= r_fwd_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // Head register: the incoming entry bypasses storage when it becomes head.
      if (w_push && ((r_count == '0) || ((r_count == CNT_W'(1)) && w_pop))) begin
        r_head_entry <= w_new;
      end else if (w_pop) begin
        r_head_entry <= r_mem[w_head_nxt_ptr];
      end
    end
  end

  assign req_ready     = w_grant;
  assign l2_valid      = (r_count != '0);
  assign command_to_L2 = r_head_entry.cmd;
  assign addr_to_L2    = r_head_entry.addr;
  assign l2_src        = r_head_entry.src;
  assign fwd_count     = r_fwd_count;
  assign occupancy     = r_count;

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// Directed bench for l1_l2_request_arbiter with NUM_CH=4, DEPTH=4.
module tb_l1_l2_request_arbiter;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 26;
  localparam int CMD_W  = 2;
  localparam int DEPTH  = 4;

  logic                     Clock;
  logic                     clear;
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*CMD_W-1:0]  req_cmd;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0]        req_ready;
  logic                     l2_valid;
  logic                     l2_ready;
  logic [CMD_W-1:0]         command_to_L2;
  logic [ADDR_W-1:0]        addr_to_L2;
  logic [1:0]               l2_src;
  logic [31:0]              fwd_count;
  logic [2:0]               occupancy;

  int n_cmp = 0;
  int n_err = 0;

  l1_l2_request_arbiter #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .CMD_W  (CMD_W),
    .DEPTH  (DEPTH)
  ) dut (
    .Clock         (Clock),
    .clear         (clear),
    .req_valid     (req_valid),
    .req_cmd       (req_cmd),
    .req_addr      (req_addr),
    .req_ready     (req_ready),
    .l2_valid      (l2_valid),
    .l2_ready      (l2_ready),
    .command_to_L2 (command_to_L2),
    .addr_to_L2    (addr_to_L2),
    .l2_src        (l2_src),
    .fwd_count     (fwd_count),
    .occupancy     (occupancy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [CMD_W-1:0] cmd, input logic [ADDR_W-1:0] addr);
    req_cmd[ch*CMD_W +: CMD_W]    = cmd;
    req_addr[ch*ADDR_W +: ADDR_W] = addr;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int n;
    int sent;
    int recv;
    logic [27:0] exp_q[$];
    logic [27:0] e;

    clear     = 1'b1;
    l2_ready  = 1'b0;
    req_valid = 4'hF;
    req_cmd   = '0;
    req_addr  = '0;

    // Reset with every channel requesting
    tick();
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_valid", 32'(l2_valid), 32'h0);
    check_eq("rst_fwd", fwd_count, 32'h0);
    check_eq("rst_occ", 32'(occupancy), 32'h0);
    check_eq("rst_cmd", 32'(command_to_L2), 32'h0);
    check_eq("rst_addr", 32'(addr_to_L2), 32'h0);
    check_eq("rst_src", 32'(l2_src), 32'h0);
    clear = 1'b0;
    #1;
    check_eq("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    tick();

    // Round robin, all channels valid, L2 always ready
    for (int i = 0; i < NUM_CH; i++) set_ch(i, CMD_W'(i), ADDR_W'(i));
    l2_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      req_valid = (k < 8) ? 4'hF : 4'h0;
      #1;
      if (k < 8) check_eq("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) begin
        check_eq("rr_valid", 32'(l2_valid), 32'h1);
        check_eq("rr_src", 32'(l2_src), 32'((k - 1) % 4));
        check_eq("rr_addr", 32'(addr_to_L2), 32'((k - 1) % 4));
        $display("pop src=%0d addr=0x%0h", l2_src, addr_to_L2);
      end
      tick();
    end
    check_eq("rr_fwd", fwd_count, 32'd8);
    check_eq("rr_occ", 32'(occupancy), 32'd0);

    // Back-pressure on channel 1
    l2_ready  = 1'b0;
    req_valid = 4'b0010;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      set_ch(1, 2'd1, ADDR_W'(32'h10 + idx));
      #1;
      check_eq("bp_ready", 32'(req_ready), (c < 4) ? 32'h2 : 32'h0);
      if (req_ready[1]) idx++;
      tick();
    end
    check_eq("bp_occ", 32'(occupancy), 32'd4);
    check_eq("bp_head", 32'(addr_to_L2), 32'h10);
    l2_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      req_valid = (idx < 6) ? 4'b0010 : 4'b0000;
      set_ch(1, 2'd1, ADDR_W'(32'h10 + idx));
      #1;
      check_eq("bp_drain_addr", 32'(addr_to_L2), 32'(32'h10 + j));
      check_eq("bp_drain_src", 32'(l2_src), 32'd1);
      check_eq("bp_drain_ready", 32'(req_ready), (j < 2) ? 32'h2 : 32'h0);
      $display("pop src=%0d addr=0x%0h", l2_src, addr_to_L2);
      if (req_ready[1]) idx++;
      tick();
    end
    check_eq("bp_occ_end", 32'(occupancy), 32'd0);
    check_eq("bp_fwd", fwd_count, 32'd14);

    // Full FIFO with simultaneous push and pop on channel 2
    l2_ready  = 1'b0;
    req_valid = 4'b0100;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      set_ch(2, 2'd2, ADDR_W'(32'h100 + n));
      #1;
      if (req_ready[2]) n++;
      tick();
    end
    check_eq("full_occ", 32'(occupancy), 32'd4);
    l2_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      set_ch(2, 2'd2, ADDR_W'(32'h100 + n));
      #1;
      check_eq("full_occ_hold", 32'(occupancy), 32'd4);
      check_eq("full_grant", 32'(req_ready), 32'h4);
      check_eq("full_head", 32'(addr_to_L2), 32'(32'h100 + j));
      $display("pop src=%0d addr=0x%0h", l2_src, addr_to_L2);
      if (req_ready[2]) n++;
      tick();
    end
    check_eq("full_fwd", fwd_count, 32'd24);
    req_valid = 4'h0;
    for (int j = 0; j < 4; j++) begin
      #1;
      check_eq("full_drain", 32'(addr_to_L2), 32'(32'h10A + j));
      tick();
    end
    check_eq("full_fwd_end", fwd_count, 32'd28);
    check_eq("full_occ_end", 32'(occupancy), 32'd0);

    // Pointer wrap: 3*DEPTH+1 requests on channel 3, random L2 back-pressure
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (sent == 13 && recv == 13) break;
      req_valid = (sent < 13) ? 4'b1000 : 4'b0000;
      set_ch(3, CMD_W'(sent % 4), ADDR_W'(32'h200 + sent));
      l2_ready = 1'($urandom_range(0, 1));
      #1;
      check_eq("wrap_occ", 32'(occupancy), 32'(exp_q.size()));
      if (l2_valid && l2_ready) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check_eq("wrap_cmd", 32'(command_to_L2), 32'(e[27:26]));
          check_eq("wrap_addr", 32'(addr_to_L2), 32'(e[25:0]));
          check_eq("wrap_src", 32'(l2_src), 32'd3);
          $display("pop src=%0d cmd=%0d addr=0x%0h", l2_src, command_to_L2, addr_to_L2);
          recv++;
        end else begin
          check_eq("wrap_pop_empty", 32'(l2_valid), 32'd0);
        end
      end
      if (req_ready[3]) begin
        exp_q.push_back({CMD_W'(sent % 4), ADDR_W'(32'h200 + sent)});
        sent++;
      end
      tick();
    end
    check_eq("wrap_sent", 32'(sent), 32'd13);
    check_eq("wrap_recv", 32'(recv), 32'd13);

    // Mid-operation clear with three entries queued
    l2_ready  = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 3; c++) begin
      set_ch(1, 2'd0, ADDR_W'(32'h300 + c));
      tick();
    end
    check_eq("mid_occ", 32'(occupancy), 32'd3);
    clear     = 1'b1;
    req_valid = 4'hF;
    #1;
    check_eq("mid_clr_ready", 32'(req_ready), 32'h0);
    tick();
    clear = 1'b0;
    #1;
    check_eq("mid_valid", 32'(l2_valid), 32'h0);
    check_eq("mid_occ_clr", 32'(occupancy), 32'd0);
    check_eq("mid_fwd", fwd_count, 32'd0);
    check_eq("mid_rr", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
